// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the MDR/MAR-to-RAM memory access controller.
// The optional timeout feature is enabled with the MEM_CTRL_TIMEOUT_EN macro.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEFAULT  = 9;
    localparam int unsigned DATA_W_DEFAULT  = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 15;
    localparam int unsigned TIMER_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_e;

    // True while a RAM request is outstanding (REQ or WAIT phase).
    function automatic logic is_access(input state_e s);
        return (s == RD_REQ) || (s == RD_WAIT) || (s == WR_REQ) || (s == WR_WAIT);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter bounding the REQ+WAIT cycles of one access; only built when
// MEM_CTRL_TIMEOUT_EN is defined.
module mem_wait_timer
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic clear,
    input  logic load,
    input  logic count,
    output logic expired
);

    logic [TIMER_W-1:0] rem_q, rem_d;

    // expired marks the last permitted cycle, so a load of N allows N cycles.
    assign expired = (rem_q == TIMER_W'(1));

    always_comb begin
        // NOTE: assigning a default first keeps every always_comb free of inferred latches.
        rem_d = rem_q;
        if (load) begin
            rem_d = TIMER_W'(TIMEOUT);
        end else if (count && !expired) begin
            rem_d = rem_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (!clear) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Memory access controller between the CPU's MAR/MDR and a handshaking RAM.
// Define MEM_CTRL_TIMEOUT_EN to bound RAM waits with mem_wait_timer and a sticky err.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              Read,
    input  logic              Write,
    input  logic [ADDR_W-1:0] MARaddr,
    input  logic [DATA_W-1:0] MDRdata,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mdr_load,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
        $error("mem_ctrl: TIMEOUT must lie in 1..255");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                re_q, re_d;
    logic                we_q, we_d;
    logic                load_q, load_d;
    logic                done_q, done_d;
    logic                accept;
    logic                timed_out;

`ifdef MEM_CTRL_TIMEOUT_EN
    logic err_q, err_d;
    logic tmr_expired;

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clock   (clock),
        .clear   (clear),
        .load    (accept),
        .count   (is_access(state_q) && !ram_ready),
        .expired (tmr_expired)
    );

    assign timed_out = tmr_expired;
    assign err       = err_q;
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    // The cycle done is high still belongs to the finished access, so IDLE
    // waits it out; a held request therefore repeats every four cycles.
    assign accept = (state_q == IDLE) && !done_q && (Read || Write);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        re_d    = 1'b0;
        we_d    = 1'b0;
        load_d  = 1'b0;
        done_d  = 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
        err_d   = accept ? 1'b0 : err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = MARaddr;
                    wdata_d = MDRdata;
                    if (Read) begin
                        state_d = RD_REQ;
                        re_d    = 1'b1;
                    end else begin
                        state_d = WR_REQ;
                        we_d    = 1'b1;
                    end
                end
            end
            RD_REQ, RD_WAIT: begin
                if (ram_ready) begin
                    rdata_d = ram_rdata;
                    load_d  = 1'b1;
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = DONE;
`ifdef MEM_CTRL_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_REQ, WR_WAIT: begin
                if (ram_ready) begin
                    state_d = DONE;
                end else if (timed_out) begin
                    state_d = DONE;
`ifdef MEM_CTRL_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = WR_WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            re_q    <= re_d;
            we_q    <= we_d;
            load_q  <= load_d;
            done_q  <= done_d;
`ifdef MEM_CTRL_TIMEOUT_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Mdatain   = rdata_q;
    assign mdr_load  = load_q;
    assign done      = done_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_re    = re_q;
    assign ram_we    = we_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: reset, zero-wait read, waited write, priority,
// async reset mid-access, wait bound (timeout or unbounded) and back-to-back reads.
module tb_mem_ctrl;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;

    logic              clock;
    logic              clear;
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] MARaddr;
    logic [DATA_W-1:0] MDRdata;
    logic [DATA_W-1:0] Mdatain;
    logic              mdr_load;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_re;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ready;

    int n_checks = 0;
    int n_errors = 0;
    int re_cnt   = 0;
    int we_cnt   = 0;
    int load_cnt = 0;
    int done_cnt = 0;

    mem_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (4)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .Read      (Read),
        .Write     (Write),
        .MARaddr   (MARaddr),
        .MDRdata   (MDRdata),
        .Mdatain   (Mdatain),
        .mdr_load  (mdr_load),
        .done      (done),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata),
        .ram_ready (ram_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse counters sampled mid-cycle.
    always @(negedge clock) begin
        if (ram_re)   re_cnt   <= re_cnt + 1;
        if (ram_we)   we_cnt   <= we_cnt + 1;
        if (mdr_load) load_cnt <= load_cnt + 1;
        if (done)     done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_Mdatain"},   64'(Mdatain),   64'h0);
        check({tag, "_mdr_load"},  64'(mdr_load),  64'h0);
        check({tag, "_done"},      64'(done),      64'h0);
        check({tag, "_err"},       64'(err),       64'h0);
        check({tag, "_ram_re"},    64'(ram_re),    64'h0);
        check({tag, "_ram_we"},    64'(ram_we),    64'h0);
        check({tag, "_ram_addr"},  64'(ram_addr),  64'h0);
        check({tag, "_ram_wdata"}, 64'(ram_wdata), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int re0, we0, load0, done0;
        logic [9:0] re_seen, done_seen;
        logic       early_done;

        clear     = 1'b0;
        Read      = 1'b0;
        Write     = 1'b0;
        MARaddr   = '0;
        MDRdata   = '0;
        ram_rdata = '0;
        ram_ready = 1'b0;

        // Reset state
        #23;
        check_all_zero("reset");
        @(posedge clock);
        #1;
        clear = 1'b1;
        step(1);

        // Zero-wait read
        ram_ready = 1'b1;
        ram_rdata = 32'hDEADBEEF;
        MARaddr   = 9'h012;
        Read      = 1'b1;
        re0 = re_cnt; load0 = load_cnt; done0 = done_cnt;
        step(1);
        Read = 1'b0;
        check("rd0_re",       64'(ram_re),   64'h1);
        check("rd0_addr",     64'(ram_addr), 64'h012);
        check("rd0_done_n",   64'(done),     64'h0);
        step(1);
        check("rd0_re_off",   64'(ram_re),   64'h0);
        check("rd0_load",     64'(mdr_load), 64'h1);
        check("rd0_data",     64'(Mdatain),  64'hDEADBEEF);
        step(1);
        check("rd0_done",     64'(done),     64'h1);
        check("rd0_load_off", 64'(mdr_load), 64'h0);
        step(1);
        check("rd0_done_off", 64'(done),     64'h0);
        check("rd0_re_cnt",   64'(re_cnt - re0),     64'd1);
        check("rd0_load_cnt", 64'(load_cnt - load0), 64'd1);
        check("rd0_done_cnt", 64'(done_cnt - done0), 64'd1);

        // Write with three wait cycles
        ram_ready = 1'b0;
        MDRdata   = 32'h10101010;
        MARaddr   = 9'h1FF;
        Write     = 1'b1;
        we0 = we_cnt; load0 = load_cnt; done0 = done_cnt;
        step(1);
        Write   = 1'b0;
        MDRdata = 32'hFFFF0000;
        MARaddr = 9'h000;
        check("wr_we",    64'(ram_we),    64'h1);
        check("wr_addr",  64'(ram_addr),  64'h1FF);
        check("wr_wdata", 64'(ram_wdata), 64'h10101010);
        for (int i = 0; i < 3; i++) begin
            step(1);
            check($sformatf("wr_wait%0d_we", i),    64'(ram_we),    64'h0);
            check($sformatf("wr_wait%0d_wdata", i), 64'(ram_wdata), 64'h10101010);
            check($sformatf("wr_wait%0d_done", i),  64'(done),      64'h0);
        end
        ram_ready = 1'b1;
        step(1);
        ram_ready = 1'b0;
        check("wr_done_early", 64'(done), 64'h0);
        step(1);
        check("wr_done",     64'(done),    64'h1);
        check("wr_mdatain",  64'(Mdatain), 64'hDEADBEEF);
        check("wr_we_cnt",   64'(we_cnt - we0),     64'd1);
        check("wr_load_cnt", 64'(load_cnt - load0), 64'd0);
        step(1);

        // Read and Write together: read wins, never a write strobe
        ram_ready = 1'b1;
        ram_rdata = 32'hCAFEF00D;
        MARaddr   = 9'h0AB;
        MDRdata   = 32'h55555555;
        Read      = 1'b1;
        Write     = 1'b1;
        we0 = we_cnt;
        step(1);
        Read  = 1'b0;
        Write = 1'b0;
        check("both_re", 64'(ram_re), 64'h1);
        check("both_we", 64'(ram_we), 64'h0);
        step(1);
        check("both_data", 64'(Mdatain), 64'hCAFEF00D);
        step(1);
        check("both_done",   64'(done),          64'h1);
        check("both_we_cnt", 64'(we_cnt - we0),  64'd0);
        step(1);

        // Asynchronous reset while waiting on a read
        ram_ready = 1'b0;
        MARaddr   = 9'h033;
        Read      = 1'b1;
        done0 = done_cnt;
        step(1);
        Read = 1'b0;
        check("rst_mid_re", 64'(ram_re), 64'h1);
        step(2);
        #2;
        clear = 1'b0;
        #1;
        check_all_zero("rst_mid");
        step(2);
        check("rst_mid_done_cnt", 64'(done_cnt - done0), 64'd0);
        clear     = 1'b1;
        ram_ready = 1'b1;
        ram_rdata = 32'h0BADF00D;
        MARaddr   = 9'h044;
        Read      = 1'b1;
        step(1);
        Read = 1'b0;
        check("rst_rec_re",   64'(ram_re),   64'h1);
        check("rst_rec_addr", 64'(ram_addr), 64'h044);
        step(1);
        check("rst_rec_data", 64'(Mdatain),  64'h0BADF00D);
        step(1);
        check("rst_rec_done", 64'(done),     64'h1);
        step(1);

`ifdef MEM_CTRL_TIMEOUT_EN
        // Timeout after four cycles without ready
        ram_ready = 1'b0;
        MARaddr   = 9'h077;
        Read      = 1'b1;
        load0 = load_cnt;
        step(1);
        Read = 1'b0;
        step(3);
        check("to_err_early",  64'(err),      64'h0);
        check("to_done_early", 64'(done),     64'h0);
        step(1);
        check("to_err",        64'(err),      64'h1);
        check("to_load",       64'(mdr_load), 64'h0);
        step(1);
        check("to_done",       64'(done),     64'h1);
        check("to_mdatain",    64'(Mdatain),  64'h0BADF00D);
        check("to_load_cnt",   64'(load_cnt - load0), 64'd0);
        step(1);
        check("to_err_sticky", 64'(err),      64'h1);
        ram_ready = 1'b1;
        ram_rdata = 32'h0F0F0F0F;
        Read      = 1'b1;
        step(1);
        Read = 1'b0;
        check("to_err_clr",    64'(err),      64'h0);
        check("to_next_re",    64'(ram_re),   64'h1);
        step(3);
`else
        // Without the timeout feature a read waits as long as the RAM needs
        ram_ready  = 1'b0;
        ram_rdata  = 32'h0F0F0F0F;
        MARaddr    = 9'h077;
        Read       = 1'b1;
        early_done = 1'b0;
        step(1);
        Read = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (done || mdr_load) early_done = 1'b1;
        end
        check("wait_no_done", 64'(early_done), 64'h0);
        check("wait_err",     64'(err),        64'h0);
        ram_ready = 1'b1;
        step(1);
        check("wait_data",    64'(Mdatain),    64'h0F0F0F0F);
        step(1);
        check("wait_done",    64'(done),       64'h1);
        step(1);
`endif

        // Back-to-back reads with Read held for ten edges
        ram_ready = 1'b1;
        ram_rdata = 32'h12345678;
        MARaddr   = 9'h100;
        Read      = 1'b1;
        re0 = re_cnt; done0 = done_cnt;
        re_seen   = '0;
        done_seen = '0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            re_seen[i]   = ram_re;
            done_seen[i] = done;
        end
        Read = 1'b0;
        check("b2b_re_pattern",   64'(re_seen),   64'b01_0001_0001);
        check("b2b_done_pattern", 64'(done_seen), 64'b00_0100_0100);
        step(1);
        check("b2b_last_done",    64'(done),      64'h1);
        check("b2b_data",         64'(Mdatain),   64'h12345678);
        step(3);
        check("b2b_re_cnt",       64'(re_cnt - re0),     64'd3);
        check("b2b_done_cnt",     64'(done_cnt - done0), 64'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
